// File: rtl/wshbn_pkg.sv
// Shared types and constants for the peripheral-bus Wishbone interconnect.
package wshbn_pkg;

  localparam int WB_ADR_W    = 8;
  localparam int WB_DAT_W    = 32;
  localparam int WB_NSLV_MAX = 4;

  // Slave slots, selected by ADR[7:4]
  localparam int SLV_PIO  = 0;
  localparam int SLV_TMR  = 1;
  localparam int SLV_UART = 2;
  localparam int SLV_SPI  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    ERR  = 2'd2
  } wb_state_e;

  // One master's request bundle
  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic                we;
    logic                stb;
    logic                cyc;
  } wb_req_t;

endpackage

// File: rtl/wshbn_rr_arbiter.sv
// Two-requester round-robin arbiter. Holds the grant until released and
// remembers the last winner so a tie goes to the other master.
module wshbn_rr_arbiter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_arb,      // bus is free, a new grant may be taken
  input  logic       i_release,  // current owner has finished
  output logic [1:0] o_gnt
);

  logic [1:0] r_gnt;
  logic       r_last;            // 1 = M1 won last, so M0 wins the next tie
  logic [1:0] w_pick;

  // Choose a winner: single requester wins outright, a tie alternates
  always_comb begin
    w_pick = i_req;
    if (i_req == 2'b11) w_pick = r_last ? 2'b01 : 2'b10;
  end

  // Grant and last-winner registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt  <= 2'b00;
      r_last <= 1'b1;
    end else if (i_release) begin
      r_gnt  <= 2'b00;
    end else if (i_arb && (|i_req)) begin
      r_gnt  <= w_pick;
      r_last <= w_pick[1];
    end
  end

  assign o_gnt = r_gnt;

endmodule

// File: rtl/wshbn_intercon.sv
// Two-master, up-to-four-slave Wishbone interconnect: round-robin grant,
// ADR[7:4] decode, combinational ACK/data return, and ERR on unmapped
// addresses or a slave that never ACKs.
module wshbn_intercon
  import wshbn_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic [WB_ADR_W-1:0]       M0_ADR_I,
  input  logic [WB_DAT_W-1:0]       M0_DAT_I,
  input  logic                      M0_WE_I,
  input  logic                      M0_STB_I,
  input  logic                      M0_CYC_I,
  output logic [WB_DAT_W-1:0]       M0_DAT_O,
  output logic                      M0_ACK_O,
  output logic                      M0_ERR_O,
  input  logic [WB_ADR_W-1:0]       M1_ADR_I,
  input  logic [WB_DAT_W-1:0]       M1_DAT_I,
  input  logic                      M1_WE_I,
  input  logic                      M1_STB_I,
  input  logic                      M1_CYC_I,
  output logic [WB_DAT_W-1:0]       M1_DAT_O,
  output logic                      M1_ACK_O,
  output logic                      M1_ERR_O,
  output logic [WB_ADR_W-1:0]       S_ADR_O,
  output logic [WB_DAT_W-1:0]       S_DAT_O,
  output logic                      S_WE_O,
  output logic                      S_CYC_O,
  output logic [WB_NSLV_MAX-1:0]    S_STB_O,
  input  logic [WB_NSLV_MAX*WB_DAT_W-1:0] S_DAT_I,
  input  logic [WB_NSLV_MAX-1:0]    S_ACK_I,
  output logic [1:0]                gnt_o,
  output logic                      tmo_o
);

  localparam logic [4:0] LP_NSLV     = 5'(NSLV);
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  wb_state_e r_state, w_state_nx;
  logic [7:0] r_cnt;
  logic [1:0] w_gnt;
  wb_req_t    w_m0, w_m1, w_own;
  logic [3:0] w_sel;
  logic [1:0] w_ssel;
  logic       w_mapped, w_req_act, w_ack, w_fire, w_release;
  logic [WB_NSLV_MAX-1:0][WB_DAT_W-1:0] w_sdat;
  logic [WB_DAT_W-1:0] w_ret_dat;

  assign w_sdat = S_DAT_I;

  // Bundle master requests and pick the owner's (zero when nobody owns)
  always_comb begin
    w_m0  = '{adr: M0_ADR_I, dat: M0_DAT_I, we: M0_WE_I, stb: M0_STB_I, cyc: M0_CYC_I};
    w_m1  = '{adr: M1_ADR_I, dat: M1_DAT_I, we: M1_WE_I, stb: M1_STB_I, cyc: M1_CYC_I};
    w_own = '0;
    if (w_gnt[1])      w_own = w_m1;
    else if (w_gnt[0]) w_own = w_m0;
  end

  assign w_sel     = w_own.adr[7:4];
  assign w_ssel    = w_sel[1:0];
  assign w_mapped  = ({1'b0, w_sel} < LP_NSLV);
  assign w_req_act = (r_state == OWN) && w_own.cyc && w_own.stb;
  assign w_ack     = w_req_act && w_mapped && S_ACK_I[w_ssel];
  // A late ACK in the last allowed cycle beats the timeout
  assign w_fire    = w_req_act && w_mapped && !w_ack && (r_cnt == LP_TMO_LAST);
  assign w_release = (r_state != IDLE) && !w_own.cyc;
  assign w_ret_dat = ((r_state == OWN) && w_mapped) ? w_sdat[w_ssel] : '0;

  // Shared slave bus follows the owner directly
  assign S_ADR_O = w_own.adr;
  assign S_DAT_O = w_own.dat;
  assign S_WE_O  = w_own.we;
  assign S_CYC_O = w_own.cyc;

  for (genvar k = 0; k < WB_NSLV_MAX; k++) begin : g_stb
    assign S_STB_O[k] = w_req_act && w_mapped && !w_fire && (w_ssel == 2'(k));
  end

  // Return path: only the owner sees ACK/ERR/data
  assign M0_ACK_O = w_gnt[0] && w_ack;
  assign M1_ACK_O = w_gnt[1] && w_ack;
  assign M0_ERR_O = w_gnt[0] && (r_state == ERR);
  assign M1_ERR_O = w_gnt[1] && (r_state == ERR);
  assign M0_DAT_O = w_gnt[0] ? w_ret_dat : '0;
  assign M1_DAT_O = w_gnt[1] ? w_ret_dat : '0;

  assign gnt_o = w_gnt;
  assign tmo_o = w_fire;

  wshbn_rr_arbiter u_arb (
    .i_clk     (CLK_I),
    .i_rst     (RST_I),
    .i_req     ({M1_CYC_I, M0_CYC_I}),
    .i_arb     (r_state == IDLE),
    .i_release (w_release),
    .o_gnt     (w_gnt)
  );

  // Next-state decode
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE: if (M0_CYC_I || M1_CYC_I) w_state_nx = OWN;
      OWN: begin
        if (!w_own.cyc)                                 w_state_nx = IDLE;
        else if ((w_own.stb && !w_mapped) || w_fire)    w_state_nx = ERR;
      end
      ERR:     w_state_nx = w_own.cyc ? OWN : IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Wait counter: counts strobed cycles without ACK, clears otherwise
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)                                    r_cnt <= '0;
    else if (w_req_act && w_mapped && !w_ack && !w_fire && w_own.cyc)
                                                  r_cnt <= r_cnt + 8'd1;
    else                                          r_cnt <= '0;
  end

endmodule
